if_fetch: RTL and testbench

Instruction fetch unit: the producer side of the instruction-word interface that the decode stage consumes. Owns the fetch PC, issues single-outstanding reads to the instruction memory port, buffers returned words with their PCs in a 2-entry queue, and presents them to decode over a valid/ready handshake. Redirects from branch/jump resolution flush the queue and restart fetch at the new PC.

---
 rtl/rv32i_types.sv | 22 ++
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/if_fetch.sv | 129 ++++++++++++
 tb/tb_if_fetch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the instruction fetch slice: FSM encoding, queue entry
// layout and the reset fetch address.
package rv32i_types;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0060;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, word} pairs; flush dominates push and pop,
// and push+pop in the same cycle is legal even when full.
module fetch_buffer
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_word,
    input  logic        i_pop,
    input  logic        i_flush,
    output logic [1:0]  o_count,
    output logic [31:0] o_head_pc,
    output logic [31:0] o_head_word
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Pointer and occupancy update; a flush empties the queue outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (w_push && !i_flush) begin
            r_mem[r_wr_ptr].pc   <= i_pc;
            r_mem[r_wr_ptr].word <= i_word;
        end
    end

    assign o_count     = r_count;
    assign o_head_pc   = r_mem[r_rd_ptr].pc;
    assign o_head_word = r_mem[r_rd_ptr].word;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the fetch PC, keeps at most one read in flight,
// queues returned words for decode and restarts fetch on a redirect.
module if_fetch
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_active;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_nxt;
    logic [31:0]  r_hold_addr;
    logic [31:0]  w_hold_addr_nxt;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count;
    logic [2:0]   w_occ_after;
    logic [31:0]  w_head_pc;
    logic [31:0]  w_head_word;

    // r_active keeps the read request low until the first edge after reset.
    assign imem_read    = r_active && (r_state != STALL);
    assign imem_address = (r_state == FLUSH) ? r_hold_addr : r_fetch_pc;

    assign instr_valid = (w_count != 2'd0);
    assign instr       = instr_valid ? w_head_word : 32'h0000_0000;
    assign instr_pc    = instr_valid ? w_head_pc : 32'h0000_0000;

    assign w_push      = r_active && (r_state == FETCH) && imem_resp && !redirect;
    assign w_pop       = instr_valid && instr_ready && !redirect;
    assign w_occ_after = {1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop};

    fetch_buffer u_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pc        (r_fetch_pc),
        .i_word      (imem_rdata),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_count     (w_count),
        .o_head_pc   (w_head_pc),
        .o_head_word (w_head_word)
    );

    // State, fetch PC and held in-flight address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FETCH;
            r_active    <= 1'b0;
            r_fetch_pc  <= RESET_PC;
            r_hold_addr <= RESET_PC;
        end else begin
            r_state     <= w_state_nxt;
            r_active    <= 1'b1;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_hold_addr <= w_hold_addr_nxt;
        end
    end

    // Next-state logic; redirect outranks response, push and pop.
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_hold_addr_nxt = r_hold_addr;
        if (redirect) begin
            w_fetch_pc_nxt = align_pc(redirect_pc);
            // The address of the abandoned request must stay on the bus until it completes.
            if (r_state == FETCH) begin
                w_hold_addr_nxt = r_fetch_pc;
            end else begin
                w_hold_addr_nxt = r_hold_addr;
            end
            if (imem_read && !imem_resp) begin
                w_state_nxt = FLUSH;
            end else begin
                w_state_nxt = FETCH;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_push) begin
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                        if (w_occ_after < 3'd2) begin
                            w_state_nxt = FETCH;
                        end else begin
                            w_state_nxt = STALL;
                        end
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end
                STALL: begin
                    if (w_occ_after < 3'd2) begin
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = STALL;
                    end
                end
                FLUSH: begin
                    if (imem_resp) begin
                        w_state_nxt = FETCH;
                    end else begin
                        w_state_nxt = FLUSH;
                    end
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// ready/latency/redirect traffic checked against an in-order delivery model.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0060;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) | 32'h0000_0013;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Bench drive knobs and model state.
    int          mem_lat = 0;
    int          mem_wait = -1;
    logic        drv_ready = 1'b0;
    int          redir_mode = 0;   // 0 none, 1 this cycle, 2 on next response
    logic [31:0] drv_rpc = 32'h0;
    int          cyc = 0;
    logic [31:0] exp_pc = RST_PC;
    logic        prev_read, prev_resp, prev_redirect, prev_hold;
    logic [31:0] prev_addr, prev_ipc, prev_instr;
    logic [31:0] addr_log[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];

    task automatic clear_logs();
        addr_log.delete();
        acc_log.delete();
        acc_cyc.delete();
    endtask

    // One clock: drive at the falling edge, check outputs that the next rising edge will see.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        imem_resp = 1'b0;
        if (imem_read) begin
            if (mem_wait < 0) mem_wait = mem_lat;
            if (mem_wait == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = memfn(imem_address);
                mem_wait   = -1;
                addr_log.push_back(imem_address);
            end else begin
                mem_wait--;
            end
        end
        instr_ready = drv_ready;
        redirect    = (redir_mode == 1) || ((redir_mode == 2) && imem_resp);
        redirect_pc = drv_rpc;
        if (redirect) redir_mode = 0;

        if (prev_redirect) chk("post_redir_valid", 32'(instr_valid), 32'd0);
        if (!instr_valid) begin
            chk("idle_instr", instr, 32'd0);
            chk("idle_pc", instr_pc, 32'd0);
        end
        if (prev_read && !prev_resp) begin
            chk("read_held", 32'(imem_read), 32'd1);
            chk("addr_stable", imem_address, prev_addr);
        end
        if (prev_hold) begin
            chk("hold_pc", instr_pc, prev_ipc);
            chk("hold_instr", instr, prev_instr);
        end
        if (redirect) begin
            exp_pc = {drv_rpc[31:2], 2'b00};
        end else if (instr_valid && instr_ready) begin
            chk("pc_seq", instr_pc, exp_pc);
            chk("word", instr, memfn(exp_pc));
            acc_log.push_back(instr_pc);
            acc_cyc.push_back(cyc);
            exp_pc = exp_pc + 32'd4;
        end

        prev_read     = imem_read;
        prev_resp     = imem_resp;
        prev_addr     = imem_address;
        prev_redirect = redirect;
        prev_hold     = instr_valid && !instr_ready && !redirect;
        prev_ipc      = instr_pc;
        prev_instr    = instr;
    endtask

    // Assert reset now (asynchronously), check outputs, release on a later falling edge.
    task automatic do_reset();
        rst         = 1'b0;
        imem_resp   = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        redir_mode  = 0;
        mem_wait    = -1;
        #1;
        chk("rst_read", 32'(imem_read), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst           = 1'b1;
        exp_pc        = RST_PC;
        prev_read     = 1'b0;
        prev_resp     = 1'b0;
        prev_redirect = 1'b0;
        prev_hold     = 1'b0;
        clear_logs();
    endtask

    task automatic run_until(input int n_addr, input int n_acc, input string tag);
        int k = 0;
        while (((addr_log.size() < n_addr) || (acc_log.size() < n_acc)) && (k < 60)) begin
            cycle();
            k++;
        end
        chk(tag, 32'((addr_log.size() >= n_addr) && (acc_log.size() >= n_acc)), 32'd1);
    endtask

    // Complete the read of RESET_PC, then redirect while the next read is still pending.
    task automatic start_flush(input logic [31:0] rpc);
        mem_lat   = 0;
        drv_ready = 1'b1;
        run_until(1, 0, "boot_timeout");
        mem_lat    = 3;
        redir_mode = 1;
        drv_rpc    = rpc;
        cycle();
        chk("flush_noresp", 32'(imem_resp), 32'd0);
        chk("flush_addr", imem_address, 32'h0000_0064);
    endtask

    initial begin
        rst         = 1'b0;
        imem_resp   = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;

        // Back-to-back fetch with a one-cycle memory and always-ready decode.
        do_reset();
        mem_lat   = 0;
        drv_ready = 1'b1;
        run_until(3, 3, "t1_timeout");
        chk("t1_addr0", qat(addr_log, 0), 32'h60);
        chk("t1_addr1", qat(addr_log, 1), 32'h64);
        chk("t1_addr2", qat(addr_log, 2), 32'h68);
        chk("t1_pc0", qat(acc_log, 0), 32'h60);
        chk("t1_pc2", qat(acc_log, 2), 32'h68);
        chk("t1_b2b", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);

        // Decode stalls: exactly two words queued, then drain and resume.
        @(negedge clk);
        do_reset();
        drv_ready = 1'b0;
        mem_lat   = 0;
        repeat (6) cycle();
        chk("t2_stall_read", 32'(imem_read), 32'd0);
        chk("t2_nwords", 32'(addr_log.size()), 32'd2);
        chk("t2_head", instr_pc, 32'h60);
        clear_logs();
        drv_ready = 1'b1;
        run_until(1, 3, "t2_timeout");
        chk("t2_pc0", qat(acc_log, 0), 32'h60);
        chk("t2_pc1", qat(acc_log, 1), 32'h64);
        chk("t2_resume", qat(addr_log, 0), 32'h68);

        // Redirect with a slow read in flight.
        @(negedge clk);
        do_reset();
        start_flush(32'h0000_0103);
        clear_logs();
        run_until(2, 1, "t3_timeout");
        chk("t3_held", qat(addr_log, 0), 32'h64);
        chk("t3_new", qat(addr_log, 1), 32'h100);
        chk("t3_first", qat(acc_log, 0), 32'h100);

        // Redirect coinciding with a response and a pop.
        @(negedge clk);
        do_reset();
        drv_ready = 1'b0;
        mem_lat   = 0;
        repeat (4) cycle();
        drv_ready = 1'b1;
        cycle();
        redir_mode = 2;
        drv_rpc    = 32'h0000_0200;
        cycle();
        chk("t4_redir_resp", 32'(redirect && imem_resp && instr_valid), 32'd1);
        clear_logs();
        cycle();
        chk("t4_empty", 32'(instr_valid), 32'd0);
        run_until(1, 1, "t4_timeout");
        chk("t4_addr", qat(addr_log, 0), 32'h200);
        chk("t4_first", qat(acc_log, 0), 32'h200);

        // Fetch PC wraps past the top of the address space.
        @(negedge clk);
        do_reset();
        drv_ready = 1'b1;
        mem_lat   = 0;
        repeat (3) cycle();
        redir_mode = 1;
        drv_rpc    = 32'hFFFF_FFFC;
        cycle();
        clear_logs();
        run_until(2, 2, "t5_timeout");
        chk("t5_addr0", qat(addr_log, 0), 32'hFFFF_FFFC);
        chk("t5_addr1", qat(addr_log, 1), 32'h0000_0000);
        chk("t5_pc1", qat(acc_log, 1), 32'h0000_0000);

        // Reset asserted while a discarded read is still pending.
        @(negedge clk);
        do_reset();
        start_flush(32'h0000_0300);
        @(negedge clk);
        chk("t6_flush_read", 32'(imem_read), 32'd1);
        do_reset();
        drv_ready = 1'b1;
        mem_lat   = 0;
        run_until(1, 1, "t6_timeout");
        chk("t6_restart", qat(addr_log, 0), 32'h60);
        chk("t6_first", qat(acc_log, 0), 32'h60);

        // Random traffic.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drv_ready = ($urandom_range(0, 9) < 7);
            mem_lat   = $urandom_range(0, 3);
            if ((redir_mode == 0) && ($urandom_range(0, 99) < 4)) begin
                redir_mode = $urandom_range(1, 2);
                if ($urandom_range(0, 3) == 0) drv_rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else drv_rpc = $urandom;
            end
            cycle();
        end
        chk("rand_progress", 32'(acc_log.size() > 200), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
